// File: rtl/intrpt_ctrl_pkg.sv
// Shared constants for the interrupt controller: line count, register map,
// FSM state encoding, and the fixed-priority pick helper.
package intrpt_ctrl_pkg;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  localparam logic [1:0] ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd2;
  localparam logic [1:0] ADDR_CAUSE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Lowest set index wins; scanning downward leaves the lowest one last.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = i[ID_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/intrpt_ctrl_irq_sync.sv
// Two-flop synchronizer for one external interrupt line plus a rising-edge
// detect on the synchronized level.
module intrpt_ctrl_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/intrpt_ctrl.sv
// Interrupt controller: per-line sync/edge detect, ENABLE/PENDING/EDGE_SEL/CAUSE
// registers, and a request/acknowledge handshake with the control-unit FSM.
//
// state   | meaning
// IDLE    | no request outstanding, arbitrating enabled pending lines
// REQ     | intrpt_vld high, waiting for intrpt_taken
// SERVICE | handler running, waiting for mie to return to 1
module intrpt_ctrl
  import intrpt_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       mie,
  input  logic       intrpt_taken,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       intrpt_vld,
  output logic [2:0] intrpt_id
);

  logic [NUM_IRQ-1:0] sync2;
  logic [NUM_IRQ-1:0] rise;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    intrpt_ctrl_irq_sync u_irq_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_i  (irq_in[g]),
      .sync_o (sync2[g]),
      .rise_o (rise[g])
    );
  end

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
  logic [7:0]         cause_q, cause_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               vld_q, vld_d;
  logic               mie_q;

  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] req_mask;
  logic               taken_clr;
  logic               abort;

  assign taken_clr = (state_q == ST_REQ) && intrpt_taken;
  assign req_mask  = pending_q & enable_q;
  assign abort     = !mie || !enable_q[id_q] || !pending_q[id_q];

  always_comb begin
    enable_d   = enable_q;
    edge_sel_d = edge_sel_q;
    w1c        = '0;
    if (reg_we) begin
      case (reg_addr)
        ADDR_ENABLE:   enable_d   = reg_wdata;
        ADDR_PENDING:  w1c        = reg_wdata;
        ADDR_EDGE_SEL: edge_sel_d = reg_wdata;
        default:       ;
      endcase
    end
  end

  // A new edge beats a same-cycle clear so that no edge is ever dropped.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!edge_sel_q[i])
        pending_d[i] = sync2[i];
      else if (rise[i])
        pending_d[i] = 1'b1;
      else if (w1c[i] || (taken_clr && (id_q == i[ID_W-1:0])))
        pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      enable_q   <= '0;
      pending_q  <= '0;
      edge_sel_q <= '1;
      cause_q    <= '0;
      id_q       <= '0;
      vld_q      <= 1'b0;
      mie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      edge_sel_q <= edge_sel_d;
      cause_q    <= cause_d;
      id_q       <= id_d;
      vld_q      <= vld_d;
      mie_q      <= mie;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (mie && (|req_mask)) state_d = ST_REQ;
      ST_REQ: begin
        if (intrpt_taken) state_d = ST_SERVICE;
        else if (abort)   state_d = ST_IDLE;
      end
      ST_SERVICE: if (!mie_q && mie) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    id_d    = id_q;
    cause_d = cause_q;
    vld_d   = (state_d == ST_REQ);
    if ((state_q == ST_IDLE) && (state_d == ST_REQ)) id_d = lowest_idx(req_mask);
    if (taken_clr) cause_d = {1'b1, 4'b0000, id_q};
  end

  always_comb begin
    case (reg_addr)
      ADDR_ENABLE:   reg_rdata = enable_q;
      ADDR_PENDING:  reg_rdata = pending_q;
      ADDR_EDGE_SEL: reg_rdata = edge_sel_q;
      default:       reg_rdata = cause_q;
    endcase
  end

  assign intrpt_vld = vld_q;
  assign intrpt_id  = id_q;

endmodule

// File: tb/tb_intrpt_ctrl.sv
// Directed bench for intrpt_ctrl: a per-cycle vector table for the basic
// edge-line flow, then hand-written sequences for the multi-cycle corners.
module tb_intrpt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       mie;
  logic       intrpt_taken;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       intrpt_vld;
  logic [2:0] intrpt_id;

  int total = 0;
  int bad   = 0;

  intrpt_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .mie          (mie),
    .intrpt_taken (intrpt_taken),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .intrpt_vld   (intrpt_vld),
    .intrpt_id    (intrpt_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] irq;
    logic       mie;
    logic       taken;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr;
    logic       exp_vld;
    logic [2:0] exp_id;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h want=%02h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    chk(name, reg_rdata, exp);
  endtask

  task automatic chk_out(input string name, input logic vld, input logic [2:0] id);
    chk({name, "_vld"}, 8'(intrpt_vld), 8'(vld));
    if (vld) chk({name, "_id"}, 8'(intrpt_id), 8'(id));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    mie          = 1'b0;
    irq_in       = 8'h00;
    intrpt_taken = 1'b0;
    reg_we       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // irq, mie, taken, we, waddr, wdata, raddr, exp_vld, exp_id, exp_rd
    vecs[0]  = '{8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h01, 2'd0, 1'b0, 3'd0, 8'h01};
    vecs[1]  = '{8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 8'h01, 2'd2, 1'b0, 3'd0, 8'h01};
    vecs[2]  = '{8'h01, 1'b1, 1'b0, 1'b1, 2'd3, 8'h55, 2'd3, 1'b0, 3'd0, 8'h00};
    vecs[3]  = '{8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b0, 3'd0, 8'h00};
    vecs[4]  = '{8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b0, 3'd0, 8'h01};
    vecs[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b1, 3'd0, 8'h01};
    vecs[6]  = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 3'd0, 8'h80};
    vecs[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b0, 3'd0, 8'h00};
    vecs[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 3'd0, 8'h80};
    vecs[9]  = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd1, 1'b0, 3'd0, 8'h00};
    vecs[10] = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0, 8'h01};

    rst = 1'b1; irq_in = 8'h00; mie = 1'b0; intrpt_taken = 1'b0;
    reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = 8'h00;

    // Reset must beat a simultaneous write and acknowledge.
    reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 8'hAA; intrpt_taken = 1'b1;
    tick();
    tick();
    rst = 1'b0; reg_we = 1'b0; intrpt_taken = 1'b0;
    chk_out("rst", 1'b0, 3'd0);
    chk("rst_id", 8'(intrpt_id), 8'h00);
    chk_reg("rst_enable", 2'd0, 8'h00);
    chk_reg("rst_pending", 2'd1, 8'h00);
    chk_reg("rst_edge_sel", 2'd2, 8'hFF);
    chk_reg("rst_cause", 2'd3, 8'h00);

    // Single edge line 0: request on the 4th edge, acknowledge, return.
    for (int i = 0; i < 11; i++) begin
      irq_in       = vecs[i].irq;
      mie          = vecs[i].mie;
      intrpt_taken = vecs[i].taken;
      reg_we       = vecs[i].we;
      reg_addr     = vecs[i].waddr;
      reg_wdata    = vecs[i].wdata;
      tick();
      reg_we = 1'b0;
      chk($sformatf("vec%0d_vld", i), 8'(intrpt_vld), 8'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_id", i), 8'(intrpt_id), 8'(vecs[i].exp_id));
      chk_reg($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
    end
    intrpt_taken = 1'b0;

    // Lines 5 and 2 together; a later line 1 must not preempt a live request.
    do_reset();
    wr(2'd0, 8'hFF);
    mie = 1'b1;
    irq_in = 8'h24; tick(); tick();
    irq_in = 8'h00; tick();
    chk_out("pri_e3", 1'b0, 3'd0);
    chk_reg("pri_pend", 2'd1, 8'h24);
    tick();
    chk_out("pri_e4", 1'b1, 3'd2);
    intrpt_taken = 1'b1; tick(); intrpt_taken = 1'b0;
    chk_out("pri_taken", 1'b0, 3'd0);
    chk_reg("pri_cause2", 2'd3, 8'h82);
    chk_reg("pri_pend2", 2'd1, 8'h20);
    mie = 1'b0; tick();
    mie = 1'b1; tick();
    chk_out("pri_ret", 1'b0, 3'd0);
    tick();
    chk_out("pri_next", 1'b1, 3'd5);
    irq_in = 8'h02; tick(); tick();
    irq_in = 8'h00; tick(); tick();
    chk_out("hold_id5", 1'b1, 3'd5);
    chk_reg("hold_pend", 2'd1, 8'h22);
    intrpt_taken = 1'b1; tick(); intrpt_taken = 1'b0;
    chk_reg("hold_cause5", 2'd3, 8'h85);
    chk_reg("hold_pend2", 2'd1, 8'h02);
    mie = 1'b0; tick();
    mie = 1'b1; tick(); tick();
    chk_out("late_id1", 1'b1, 3'd1);

    // Disabling the requested line aborts back to IDLE, CAUSE untouched.
    wr(2'd0, 8'h00);
    tick();
    chk_out("abort", 1'b0, 3'd0);
    chk_reg("abort_cause", 2'd3, 8'h85);
    chk_reg("abort_pend", 2'd1, 8'h02);
    tick();
    chk_out("abort_idle", 1'b0, 3'd0);
    wr(2'd0, 8'h02);
    tick();
    chk_out("reenable", 1'b1, 3'd1);

    // Level line 3: W1C has no effect; clears 3 edges after irq drops.
    do_reset();
    wr(2'd2, 8'hF7);
    irq_in = 8'h08; tick(); tick();
    chk_reg("lvl_e2", 2'd1, 8'h00);
    tick();
    chk_reg("lvl_e3", 2'd1, 8'h08);
    wr(2'd1, 8'h08);
    chk_reg("lvl_w1c", 2'd1, 8'h08);
    irq_in = 8'h00; tick(); tick();
    chk_reg("lvl_drop2", 2'd1, 8'h08);
    tick();
    chk_reg("lvl_drop3", 2'd1, 8'h00);

    // New edge on line 0 in the same cycle as taken for id 0.
    do_reset();
    wr(2'd0, 8'h01);
    mie = 1'b1;
    irq_in = 8'h01; tick(); tick();
    irq_in = 8'h00; tick(); tick();
    chk_out("race_req", 1'b1, 3'd0);
    tick();
    irq_in = 8'h01; tick(); tick();
    chk_out("race_hold", 1'b1, 3'd0);
    irq_in = 8'h00; intrpt_taken = 1'b1; tick(); intrpt_taken = 1'b0;
    chk_out("race_taken", 1'b0, 3'd0);
    chk_reg("race_pend", 2'd1, 8'h01);
    chk_reg("race_cause", 2'd3, 8'h80);

    // Reset while in SERVICE with an edge in flight.
    irq_in = 8'h01; tick();
    rst = 1'b1; reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 8'hFF; intrpt_taken = 1'b1;
    tick();
    rst = 1'b0; reg_we = 1'b0; intrpt_taken = 1'b0; irq_in = 8'h00;
    chk("svc_rst_vld", 8'(intrpt_vld), 8'h00);
    chk("svc_rst_id", 8'(intrpt_id), 8'h00);
    chk_reg("svc_rst_en", 2'd0, 8'h00);
    chk_reg("svc_rst_pend", 2'd1, 8'h00);
    chk_reg("svc_rst_es", 2'd2, 8'hFF);
    chk_reg("svc_rst_cause", 2'd3, 8'h00);
    tick(); tick(); tick();
    chk_reg("svc_rst_flush", 2'd1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intrpt_ctrl.md
INTRPT_CTRL -- requirements
Module: intrpt_ctrl

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high; clock clk.
REQ-002 The ports SHALL be as follows:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- irq_in  in  8  asynchronous external interrupt lines, active-high
- mie  in  1  global interrupt enable from the CSR file
- intrpt_taken  in  1  acknowledge from the control-unit FSM interrupt state
- reg_we  in  1  register write strobe
- reg_addr  in  2  register select
- reg_wdata  in  8  register write data
- reg_rdata  out  8  register read data, combinational from reg_addr
- intrpt_vld  out  1  request to the control-unit FSM, registered
- intrpt_id  out  3  index of the requesting line, registered, valid while intrpt_vld=1

Function
REQ-003 Each irq_in bit SHALL pass through a 2-flop synchronizer; sync2 = synchronized level.
REQ-004 Register map SHALL be: 0 ENABLE rw; 1 PENDING read, write-1-to-clear; 2 EDGE_SEL rw (1=rising edge, 0=level); 3 CAUSE ro {valid[7], 0000, id[2:0]}; writes to 3 ignored.
REQ-005 Edge line: pending bit SHALL set on the clk edge where sync2=1 and previous sync2=0, so it is visible 3 edges after irq_in is first sampled high.
REQ-006 Level line: pending bit SHALL load sync2 every edge; W1C and taken SHALL have no effect on it.
REQ-007 Edge-line pending SHALL clear on W1C or on taken for the latched id; a new edge in the same cycle SHALL win (set), so no edge is lost.
REQ-008 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-009 IDLE: if mie=1 and (PENDING & ENABLE)!=0 -> REQ, latching the lowest set index into intrpt_id; intrpt_vld=1 from the next cycle.
REQ-010 REQ: intrpt_vld held at 1 and intrpt_id stable until intrpt_taken=1; on taken -> SERVICE, CAUSE <= {1, id}, intrpt_vld <= 0.
REQ-011 REQ abort: if mie=0, or the latched line's ENABLE or pending bit is 0, while taken=0 -> IDLE, intrpt_vld <= 0; CAUSE unchanged.
REQ-012 SERVICE: intrpt_vld=0; exit to IDLE on a rising edge of mie (registered mie=0, current mie=1), i.e. return from the handler.
REQ-013 intrpt_taken outside REQ SHALL be ignored.
REQ-014 A higher-priority (lower-index) line arriving while in REQ SHALL NOT change intrpt_id; it is arbitrated after the return to IDLE.
REQ-015 Total latency irq_in high to intrpt_vld high SHALL be 4 clk edges when mie=1 and the line is enabled and in IDLE.

Reset
REQ-016 On rst: state IDLE, sync flops 0, PENDING 0x00, ENABLE 0x00, EDGE_SEL 0xFF, CAUSE 0x00, intrpt_vld 0, intrpt_id 0.
REQ-017 rst asserted in REQ or SERVICE SHALL return to IDLE on that edge with intrpt_vld 0 the following cycle; no pending edge is retained.
REQ-018 rst SHALL take priority over reg_we and intrpt_taken in the same cycle.

Structure
REQ-019 The state encoding, register addresses, and NUM_IRQ=8 SHALL live in the shared Defines.svh.
REQ-020 The synchronizer plus edge detector SHALL be one sub-module, irq_sync, instantiated per line.

Verification
REQ-021 ENABLE=0x01, EDGE_SEL=0x01, mie=1, irq_in[0] pulse for 2 cycles -> intrpt_vld=1 and id=0 on edge 4; taken -> CAUSE=0x80, PENDING=0x00, vld=0.
REQ-022 Lines 5 and 2 pending the same cycle, ENABLE=0xFF -> id=2; after taken and a mie 0->1 sequence -> id=5 is served next.
REQ-023 Level line 3 held high, W1C 0x08 -> PENDING bit 3 stays 1; after irq_in[3] drops -> bit clears 3 edges later.
REQ-024 In REQ with id=1, ENABLE written to 0x00 -> vld=0 next cycle, state IDLE, CAUSE unchanged.
REQ-025 Edge on line 0 in the same cycle as taken for id=0 -> PENDING bit 0 remains 1 after the edge.
REQ-026 rst during SERVICE -> all registers at reset values next cycle; pending edge-line activity is discarded.
